// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake, an optional
// two-entry skid buffer and a flush that turns the stage into a NOP bubble.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] FLUSH_VAL = 64'h0000_0000_0000_0013,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             in_xfer;
  logic             out_xfer;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = main_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      logic             skid_valid;
      logic [WIDTH-1:0] skid_data;

      // in_ready comes straight from a flop so upstream never sees a path through out_ready
      assign in_ready  = ~skid_valid;
      assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

      always_ff @(posedge clk) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= FLUSH_VAL;
          skid_valid <= 1'b0;
          skid_data  <= FLUSH_VAL;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= FLUSH_VAL;
          skid_valid <= 1'b0;
          skid_data  <= FLUSH_VAL;
        end else if (!main_valid) begin
          if (in_xfer) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end
        end else if (out_xfer) begin
          // skid holds the older entry, so it must drain before in_data to keep FIFO order
          if (skid_valid) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            skid_data  <= FLUSH_VAL;
          end else if (in_xfer) begin
            main_data  <= in_data;
          end else begin
            main_valid <= 1'b0;
            main_data  <= FLUSH_VAL;
          end
        end else if (in_xfer) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end else begin : g_noskid
      assign in_ready  = ~main_valid | out_ready;
      assign occupancy = {1'b0, main_valid};

      always_ff @(posedge clk) begin
        if (!rst) begin
          main_valid <= 1'b0;
          main_data  <= FLUSH_VAL;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= FLUSH_VAL;
        end else if (in_xfer) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (out_xfer) begin
          main_valid <= 1'b0;
          main_data  <= FLUSH_VAL;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, each tracked by a
// queue scoreboard updated from handshakes, plus per-scenario directed checks.
module tb_pipe_stage_reg;

  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [63:0] s_in_data = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic [63:0] s_out_data;
  logic [1:0]  s_occ;

  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [63:0] n_in_data = '0;
  logic        n_out_valid;
  logic        n_out_ready = 1'b0;
  logic [63:0] n_out_data;
  logic [1:0]  n_occ;

  int checks = 0;
  int errors = 0;

  logic [63:0] s_q[$];
  logic [63:0] n_q[$];
  bit          s_model_ok = 1'b0;
  bit          n_model_ok = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(64), .FLUSH_VAL(NOP), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occ)
  );

  pipe_stage_reg #(.WIDTH(64), .FLUSH_VAL(NOP), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occ)
  );

  // Scoreboard for the skid instance: compare against the queue, then apply the coming edge
  always @(negedge clk) begin
    logic        exp_v;
    logic        exp_rdy;
    logic [63:0] exp_d;
    exp_v   = (s_q.size() != 0);
    exp_rdy = (s_q.size() < 2);
    exp_d   = exp_v ? s_q[0] : NOP;
    if (s_model_ok) begin
      checks++;
      if (s_occ !== 2'(s_q.size())) begin
        errors++;
        $display("[TB] FAIL skid_occupancy got %0d expected %0d", s_occ, s_q.size());
      end
      checks++;
      if (s_out_valid !== exp_v) begin
        errors++;
        $display("[TB] FAIL skid_out_valid got %b expected %b", s_out_valid, exp_v);
      end
      checks++;
      if (s_out_data !== exp_d) begin
        errors++;
        $display("[TB] FAIL skid_out_data got %h expected %h", s_out_data, exp_d);
      end
      checks++;
      if (s_in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL skid_in_ready got %b expected %b", s_in_ready, exp_rdy);
      end
    end
    if (!rst) begin
      s_q.delete();
      s_model_ok = 1'b1;
    end else if (s_model_ok) begin
      if (exp_v && s_out_ready) void'(s_q.pop_front());
      if (flush) s_q.delete();
      else if (s_in_valid && exp_rdy) s_q.push_back(s_in_data);
    end
  end

  // Scoreboard for the no-skid instance; its in_ready depends on out_ready in the same cycle
  always @(negedge clk) begin
    logic        exp_v;
    logic        exp_rdy;
    logic [63:0] exp_d;
    exp_v   = (n_q.size() != 0);
    exp_rdy = (n_q.size() == 0) || n_out_ready;
    exp_d   = exp_v ? n_q[0] : NOP;
    if (n_model_ok) begin
      checks++;
      if (n_occ !== 2'(n_q.size())) begin
        errors++;
        $display("[TB] FAIL noskid_occupancy got %0d expected %0d", n_occ, n_q.size());
      end
      checks++;
      if (n_out_valid !== exp_v) begin
        errors++;
        $display("[TB] FAIL noskid_out_valid got %b expected %b", n_out_valid, exp_v);
      end
      checks++;
      if (n_out_data !== exp_d) begin
        errors++;
        $display("[TB] FAIL noskid_out_data got %h expected %h", n_out_data, exp_d);
      end
      checks++;
      if (n_in_ready !== exp_rdy) begin
        errors++;
        $display("[TB] FAIL noskid_in_ready got %b expected %b", n_in_ready, exp_rdy);
      end
    end
    if (!rst) begin
      n_q.delete();
      n_model_ok = 1'b1;
    end else if (n_model_ok) begin
      if (exp_v && n_out_ready) void'(n_q.pop_front());
      if (flush) n_q.delete();
      else if (n_in_valid && exp_rdy) n_q.push_back(n_in_data);
    end
  end

  task automatic send_s(input logic [63:0] d);
    bit acc;
    acc = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = d;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = s_in_ready;
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL send_s_timeout got not-accepted expected accepted data %h", d);
    end
  endtask

  task automatic send_n(input logic [63:0] d);
    bit acc;
    acc = 1'b0;
    n_in_valid = 1'b1;
    n_in_data  = d;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = n_in_ready;
      @(posedge clk);
      #1;
    end
    n_in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL send_n_timeout got not-accepted expected accepted data %h", d);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60 && (s_q.size() != 0 || n_q.size() != 0); t++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (s_q.size() != 0 || n_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout got %0d/%0d entries expected 0/0", s_q.size(), n_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_skid got v=%b d=%h occ=%0d rdy=%b expected v=0 d=%h occ=0 rdy=1",
               s_out_valid, s_out_data, s_occ, s_in_ready, NOP);
    end
    checks++;
    if (n_out_valid !== 1'b0 || n_out_data !== NOP || n_occ !== 2'd0 || n_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_noskid got v=%b d=%h occ=%0d rdy=%b expected v=0 d=%h occ=0 rdy=1",
               n_out_valid, n_out_data, n_occ, n_in_ready, NOP);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] v[3];
    v[0] = {32'h100, 32'h13};
    v[1] = {32'h104, 32'h93};
    v[2] = {32'h108, 32'h113};
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_s(v[i]);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== v[i] || s_in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_%0d got v=%b d=%h rdy=%b expected v=1 d=%h rdy=1",
                 i, s_out_valid, s_out_data, s_in_ready, v[i]);
      end
    end
    wait_drain();
  endtask

  task automatic test_back_pressure();
    s_out_ready = 1'b0;
    send_s(64'hA);
    send_s(64'hB);
    s_in_valid = 1'b1;
    s_in_data  = 64'hC;
    checks++;
    if (s_in_ready !== 1'b0 || s_occ !== 2'd2 || s_out_data !== 64'hA) begin
      errors++;
      $display("[TB] FAIL backpressure got rdy=%b occ=%0d d=%h expected rdy=0 occ=2 d=a",
               s_in_ready, s_occ, s_out_data);
    end
    s_out_ready = 1'b1;
    send_s(64'hC);
    wait_drain();
  endtask

  task automatic test_flush();
    s_out_ready = 1'b0;
    send_s(64'hF0);
    send_s(64'hF1);
    flush = 1'b1;
    s_in_valid = 1'b1;
    s_in_data  = 64'hDEAD;
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_in_valid = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_full got v=%b d=%h occ=%0d rdy=%b expected bubble",
               s_out_valid, s_out_data, s_occ, s_in_ready);
    end
    send_s(64'hF2);
    flush = 1'b1;
    s_in_valid = 1'b1;
    s_in_data  = 64'hDEAD;
    @(posedge clk);
    #1;
    flush = 1'b0;
    s_in_valid = 1'b0;
    s_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_out_valid !== 1'b0 || s_out_data !== NOP) begin
        errors++;
        $display("[TB] FAIL flush_discard got v=%b d=%h expected v=0 d=%h", s_out_valid, s_out_data, NOP);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    s_out_ready = 1'b0;
    n_out_ready = 1'b0;
    send_s(64'h71);
    send_s(64'h72);
    send_n(64'h81);
    rst = 1'b0;
    s_in_valid = 1'b1;
    s_in_data  = 64'hBEEF;
    s_out_ready = 1'b1;
    n_in_valid = 1'b1;
    n_in_data  = 64'hBEEF;
    n_out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP || s_occ !== 2'd0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_skid got v=%b d=%h occ=%0d rdy=%b expected reset values",
               s_out_valid, s_out_data, s_occ, s_in_ready);
    end
    checks++;
    if (n_out_valid !== 1'b0 || n_out_data !== NOP || n_occ !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_noskid got v=%b d=%h occ=%0d expected reset values",
               n_out_valid, n_out_data, n_occ);
    end
    rst = 1'b1;
    s_in_valid = 1'b0;
    n_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_mid_reappear got %b/%b expected 0/0", s_out_valid, n_out_valid);
      end
    end
  endtask

  task automatic test_noskid();
    n_out_ready = 1'b0;
    send_n(64'h900);
    n_in_valid = 1'b1;
    n_in_data  = 64'h901;
    #1;
    checks++;
    if (n_in_ready !== 1'b0 || n_occ !== 2'd1) begin
      errors++;
      $display("[TB] FAIL noskid_stall got rdy=%b occ=%0d expected rdy=0 occ=1", n_in_ready, n_occ);
    end
    n_out_ready = 1'b1;
    #1;
    checks++;
    if (n_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noskid_comb_ready got %b expected 1", n_in_ready);
    end
    for (int i = 1; i < 5; i++) begin
      n_in_data = 64'h900 + 64'(i);
      @(posedge clk);
      #1;
      checks++;
      if (n_out_valid !== 1'b1 || n_out_data !== 64'h900 + 64'(i) || n_occ > 2'd1) begin
        errors++;
        $display("[TB] FAIL noskid_passthru_%0d got v=%b d=%h occ=%0d expected v=1 d=%h occ<=1",
                 i, n_out_valid, n_out_data, n_occ, 64'h900 + 64'(i));
      end
    end
    n_in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_drain();
    s_out_ready = 1'b1;
    send_s(64'h55);
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 64'h55) begin
      errors++;
      $display("[TB] FAIL drain_present got v=%b d=%h expected v=1 d=55", s_out_valid, s_out_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== NOP) begin
      errors++;
      $display("[TB] FAIL drain_empty got v=%b d=%h expected v=0 d=%h", s_out_valid, s_out_data, NOP);
    end
  endtask

  initial begin
    $display("[TB] pipe_stage_reg bench start");
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    test_noskid();
    test_drain();
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got hang expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
